softstart_ramp_seq: RTL and testbench
=====================================

Name: softstart_ramp_seq

Overview:
- Digital sequencer inside the step-down soft-start block, directly upstream of the soft-start NAND2 gating cell.
- Produces a monotonic reference-DAC ramp code after a start-up blanking interval.
- Drives `drv_en`, which feeds NAND2 input `i0`. The NAND2 output is the active-low driver gate enable.
- Aborts and holds off on fault. A fault can only be cleared by re-enabling.

Parameters:
- CODE_W, 8, width of ramp code.
- PRESCALE, 16, clock cycles per ramp step. Legal range 1..4096.
- BLANK_CYC, 64, clock cycles between enable and ramp start. Legal range 1..4096.
- FINAL_CODE, 255, terminal ramp code. Legal range 1..2^CODE_W-1.

Ports:
- clk  input  1  sequencer clock.
- rst  input  1  asynchronous, active-high reset.
- CELV  input  1  supply.
- CELG  input  1  ground.
- SUB  input  1  substrate.
- en  input  1  converter enable, synchronous to clk.
- fault  input  1  UVLO/OCP fault summary, synchronous to clk, level-sensitive.
- ss_code  output  CODE_W  ramp code to reference DAC.
- ramp_act  output  1  high while ramping.
- ss_done  output  1  ramp complete. Equals power-good-eligible.
- drv_en  output  1  driver enable to the NAND2 `i0`.
- fault_lat  output  1  latched fault indicator.

Behaviour:
- Interface: single clock `clk`. Reset `rst` is asynchronous and active-high.
- Reset values: all outputs are registered and reset to 0. State resets to IDLE. Both counters reset to 0.
- States: IDLE, BLANK, RAMP, DONE, FAULT.
- Priority at each edge, highest first: fault, then en low, then normal progression.
- Any state, `fault`=1: next state is FAULT.
  - In the same edge: `ss_code`=0, `drv_en`=0, `ramp_act`=0, `ss_done`=0, `fault_lat`=1.
- FAULT: exits to IDLE only when `fault`=0 and `en`=0 are sampled together. `fault_lat` clears on that edge.
  - `en` held high across fault removal keeps the block in FAULT. Re-enable requires toggling `en`.
- BLANK, RAMP or DONE, `en`=0 (no fault): next state is IDLE. All outputs go to 0 on that edge.
- IDLE, `en`=1 sampled at edge k: next state is BLANK. Blank counter loads BLANK_CYC-1.
- BLANK: counter decrements each edge. At the edge where it reads 0:
  - next state is RAMP;
  - `drv_en`=1, `ramp_act`=1;
  - prescaler loads PRESCALE-1.
  - RAMP therefore begins at edge k+BLANK_CYC.
- RAMP: prescaler decrements each edge. At the edge where it reads 0:
  - `ss_code` increments by 1;
  - prescaler reloads PRESCALE-1.
  - `ss_code` holds steady between steps.
- RAMP, the increment that makes `ss_code`==FINAL_CODE: on the same edge, next state is DONE, `ramp_act`=0, `ss_done`=1.
  - `ss_done` therefore rises at edge k+BLANK_CYC+FINAL_CODE*PRESCALE.
  - Default parameters: 4144 cycles after edge k.
- DONE: `ss_code` holds FINAL_CODE and `drv_en`=1 while `en`=1 and `fault`=0.
- Code range: `ss_code` never exceeds FINAL_CODE and never wraps. It is monotonic non-decreasing within one ramp.
- PRESCALE=1: code steps every cycle.
- `rst` asserted mid-ramp: immediate async clear to IDLE with all outputs 0. After release, a fresh `en` high restarts from BLANK.
- Output invariants:
  - `drv_en`=1 only in RAMP or DONE.
  - `ramp_act` and `ss_done` are never both 1.

Decomposition:
- Package `softstart_pkg`:
  - state enum (IDLE, BLANK, RAMP, DONE, FAULT);
  - counter width localparam, `$clog2(4096)+1`;
  - parameter-range check macro or function.
- Sub-module `ss_tick_gen`: loadable down-counter with terminal-count pulse.
  - Ports: `clk`, `rst`, `load`, `load_val`, `en`, `tc`.
  - Instanced twice: blanking counter and step prescaler.
- FSM and code register stay in the top module.

Test Plan:
- Bench parameters: PRESCALE=2, BLANK_CYC=3, FINAL_CODE=5.
- Nominal ramp: `en` rises at edge 0 and stays high.
  - `drv_en` rises at edge 3.
  - `ss_code` takes values 1, 2, 3, 4, 5 at edges 5, 7, 9, 11, 13.
  - `ss_done`=1 at edge 13; `ramp_act`=0 from edge 13.
- Fault mid-ramp: `fault` pulses for 1 cycle at edge 8.
  - At edge 8: `ss_code`=0, `drv_en`=0, `fault_lat`=1.
  - State stays FAULT while `en` stays high.
  - `en` low with `fault` low: IDLE. `en` high again: full ramp reruns from 0.
- `en` drop in DONE: `en`=0 at edge 20, so `ss_code`=0, `ss_done`=0, `drv_en`=0 at edge 20.
- Async reset mid-ramp: `rst` asserted between edges while `ss_code`=3.
  - All outputs are 0 immediately, with no clock edge needed.
  - After release, with `en` still high, BLANK restarts and `drv_en` rises 3 cycles later.
- Simultaneous `fault`=1 and `en` 0→1 in IDLE: next state is FAULT, `fault_lat`=1, `drv_en` stays 0.
- Default parameters, nominal run: `ss_done` rises exactly 4144 edges after `en` is sampled. Code checker confirms monotonic single-LSB steps.

Source files
------------

// File: rtl/softstart_pkg.sv
// ============================================================================
// Module   : softstart_pkg
// Purpose  : Shared state encoding, counter width and parameter checks for
//            the soft-start ramp sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package softstart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BLANK = 3'd1,
    RAMP  = 3'd2,
    DONE  = 3'd3,
    FAULT = 3'd4
  } ss_state_e;

  localparam int SS_CNT_MAX = 4096;
  // One spare bit so a full-range load value never needs truncation.
  localparam int SS_CNT_W   = $clog2(SS_CNT_MAX) + 1;

  function automatic bit ss_param_ok(input int val, input int lo, input int hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ss_tick_gen.sv
// ============================================================================
// Module   : ss_tick_gen
// Purpose  : Loadable down-counter; tc flags an enabled cycle at count zero.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ss_tick_gen
  import softstart_pkg::*;
#(
  parameter int CNT_W = SS_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] count_q, count_d;

  // Counter parks at zero instead of wrapping; the owner reloads it.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = en && (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/softstart_ramp_seq.sv
// ============================================================================
// Module   : softstart_ramp_seq
// Purpose  : Soft-start sequencer: blanking, monotonic DAC ramp, fault latch.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module softstart_ramp_seq
  import softstart_pkg::*;
#(
  parameter int CODE_W     = 8,
  parameter int PRESCALE   = 16,
  parameter int BLANK_CYC  = 64,
  parameter int FINAL_CODE = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CELV,
  input  logic              CELG,
  input  logic              SUB,
  input  logic              en,
  input  logic              fault,
  output logic [CODE_W-1:0] ss_code,
  output logic              ramp_act,
  output logic              ss_done,
  output logic              drv_en,
  output logic              fault_lat
);

  if (!ss_param_ok(PRESCALE, 1, SS_CNT_MAX)) begin : g_bad_prescale
    $error("softstart_ramp_seq: PRESCALE out of range");
  end
  if (!ss_param_ok(BLANK_CYC, 1, SS_CNT_MAX)) begin : g_bad_blank
    $error("softstart_ramp_seq: BLANK_CYC out of range");
  end
  if (!ss_param_ok(FINAL_CODE, 1, (1 << CODE_W) - 1)) begin : g_bad_final
    $error("softstart_ramp_seq: FINAL_CODE out of range");
  end

  localparam logic [CODE_W-1:0]   FINAL_C   = CODE_W'(FINAL_CODE);
  localparam logic [SS_CNT_W-1:0] BLANK_LD  = SS_CNT_W'(BLANK_CYC - 1);
  localparam logic [SS_CNT_W-1:0] PRESC_LD  = SS_CNT_W'(PRESCALE - 1);

  // Supply/substrate pins exist for the cell netlist only.
  logic unused_supply;
  assign unused_supply = CELV & CELG & SUB;

  ss_state_e         state_q, state_d;
  logic [CODE_W-1:0] ss_code_q, ss_code_d;
  logic              ramp_act_q, ramp_act_d;
  logic              ss_done_q, ss_done_d;
  logic              drv_en_q, drv_en_d;
  logic              fault_lat_q, fault_lat_d;

  logic              blank_load, blank_tc;
  logic              presc_load, presc_tc;
  logic [CODE_W-1:0] code_inc;

  assign code_inc = ss_code_q + 1'b1;

  ss_tick_gen #(.CNT_W(SS_CNT_W)) u_blank_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (blank_load),
    .load_val (BLANK_LD),
    .en       (state_q == BLANK),
    .tc       (blank_tc)
  );

  ss_tick_gen #(.CNT_W(SS_CNT_W)) u_step_presc (
    .clk      (clk),
    .rst      (rst),
    .load     (presc_load),
    .load_val (PRESC_LD),
    .en       (state_q == RAMP),
    .tc       (presc_tc)
  );

  always_comb begin
    state_d     = state_q;
    ss_code_d   = ss_code_q;
    ramp_act_d  = ramp_act_q;
    ss_done_d   = ss_done_q;
    drv_en_d    = drv_en_q;
    fault_lat_d = fault_lat_q;
    blank_load  = 1'b0;
    presc_load  = 1'b0;

    if (fault) begin
      state_d     = FAULT;
      ss_code_d   = '0;
      ramp_act_d  = 1'b0;
      ss_done_d   = 1'b0;
      drv_en_d    = 1'b0;
      fault_lat_d = 1'b1;
    end else if (state_q == FAULT) begin
      // Only a deliberate en toggle releases the latch.
      if (!en) begin
        state_d     = IDLE;
        fault_lat_d = 1'b0;
      end
    end else if (!en) begin
      state_d     = IDLE;
      ss_code_d   = '0;
      ramp_act_d  = 1'b0;
      ss_done_d   = 1'b0;
      drv_en_d    = 1'b0;
      fault_lat_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d    = BLANK;
          blank_load = 1'b1;
        end
        BLANK: begin
          if (blank_tc) begin
            state_d    = RAMP;
            drv_en_d   = 1'b1;
            ramp_act_d = 1'b1;
            presc_load = 1'b1;
          end
        end
        RAMP: begin
          if (presc_tc && (ss_code_q != FINAL_C)) begin
            ss_code_d  = code_inc;
            presc_load = 1'b1;
            if (code_inc == FINAL_C) begin
              state_d    = DONE;
              ramp_act_d = 1'b0;
              ss_done_d  = 1'b1;
            end
          end
        end
        DONE: begin
          ss_code_d = FINAL_C;
          drv_en_d  = 1'b1;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ss_code_q   <= '0;
      ramp_act_q  <= 1'b0;
      ss_done_q   <= 1'b0;
      drv_en_q    <= 1'b0;
      fault_lat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_code_q   <= ss_code_d;
      ramp_act_q  <= ramp_act_d;
      ss_done_q   <= ss_done_d;
      drv_en_q    <= drv_en_d;
      fault_lat_q <= fault_lat_d;
    end
  end

  assign ss_code   = ss_code_q;
  assign ramp_act  = ramp_act_q;
  assign ss_done   = ss_done_q;
  assign drv_en    = drv_en_q;
  assign fault_lat = fault_lat_q;

endmodule

`default_nettype wire

// File: tb/tb_softstart_ramp_seq.sv
// ============================================================================
// Module   : tb_softstart_ramp_seq
// Purpose  : Self-checking bench for softstart_ramp_seq (small and default
//            parameter instances) against a cycle-count reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_softstart_ramp_seq;

  localparam int P = 2;
  localparam int B = 3;
  localparam int F = 5;
  localparam int W = 8;

  localparam int DP = 16;
  localparam int DB = 64;
  localparam int DF = 255;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         fault = 1'b0;
  logic [W-1:0] ss_code;
  logic         ramp_act, ss_done, drv_en, fault_lat;

  logic         en_d = 1'b0;
  logic [W-1:0] ss_code_d;
  logic         ramp_act_d, ss_done_d, drv_en_d, fault_lat_d;

  always #5 clk = ~clk;

  softstart_ramp_seq #(.CODE_W(W), .PRESCALE(P), .BLANK_CYC(B), .FINAL_CODE(F)) dut (
    .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en), .fault(fault), .ss_code(ss_code), .ramp_act(ramp_act),
    .ss_done(ss_done), .drv_en(drv_en), .fault_lat(fault_lat)
  );

  softstart_ramp_seq #(.CODE_W(W), .PRESCALE(DP), .BLANK_CYC(DB), .FINAL_CODE(DF)) dut_def (
    .clk(clk), .rst(rst), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .en(en_d), .fault(1'b0), .ss_code(ss_code_d), .ramp_act(ramp_act_d),
    .ss_done(ss_done_d), .drv_en(drv_en_d), .fault_lat(fault_lat_d)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: tracks when the current enable episode started and
  // derives outputs purely from elapsed cycles.
  bit m_active, m_faulted;
  int m_start, cyc;
  int e_code;
  bit e_drv, e_ramp, e_done, e_flat;

  task automatic model_reset();
    m_active = 1'b0; m_faulted = 1'b0; m_start = 0;
    e_code = 0; e_drv = 0; e_ramp = 0; e_done = 0; e_flat = 0;
  endtask

  task automatic model_edge();
    int t;
    cyc++;
    if (fault) begin
      m_faulted = 1'b1;
      m_active  = 1'b0;
    end else if (m_faulted) begin
      if (!en) m_faulted = 1'b0;
    end else if (!en) begin
      m_active = 1'b0;
    end else if (!m_active) begin
      m_active = 1'b1;
      m_start  = cyc;
    end
    e_code = 0; e_drv = 0; e_ramp = 0; e_done = 0; e_flat = m_faulted;
    if (m_active && !m_faulted && (cyc - m_start) >= B) begin
      t      = (cyc - m_start - B) / P;
      e_code = (t > F) ? F : t;
      e_drv  = 1'b1;
      e_ramp = (e_code < F);
      e_done = (e_code == F);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("ss_code",   int'(ss_code),   e_code);
    check("drv_en",    int'(drv_en),    int'(e_drv));
    check("ramp_act",  int'(ramp_act),  int'(e_ramp));
    check("ss_done",   int'(ss_done),   int'(e_done));
    check("fault_lat", int'(fault_lat), int'(e_flat));
    check("act_done_excl", int'(ramp_act & ss_done), 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int cnt;
    int prev;
    cyc = 0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_code",  int'(ss_code),   0);
    check("rst_drv",   int'(drv_en),    0);
    check("rst_flat",  int'(fault_lat), 0);
    check("rst_done",  int'(ss_done),   0);
    rst = 1'b0;
    ticks(2);

    // Nominal ramp, then en dropped in DONE at edge 20
    en = 1'b1;
    ticks(20);
    en = 1'b0;
    ticks(3);

    // One-cycle fault at edge 8, en held high, then toggle and rerun
    en = 1'b1;
    ticks(8);
    fault = 1'b1;
    tick();
    fault = 1'b0;
    ticks(4);
    en = 1'b0;
    tick();
    en = 1'b1;
    ticks(16);
    en = 1'b0;
    ticks(2);

    // Async reset while ss_code==3, no clock edge needed
    en = 1'b1;
    ticks(10);
    check("pre_rst_code", int'(ss_code), 3);
    #2 rst = 1'b1;
    #1;
    check("arst_code",  int'(ss_code),   0);
    check("arst_drv",   int'(drv_en),    0);
    check("arst_ramp",  int'(ramp_act),  0);
    check("arst_done",  int'(ss_done),   0);
    check("arst_flat",  int'(fault_lat), 0);
    model_reset();
    #1 rst = 1'b0;
    ticks(6);
    en = 1'b0;
    ticks(2);

    // Simultaneous fault and en rise from IDLE
    en = 1'b1;
    fault = 1'b1;
    tick();
    check("sim_flat", int'(fault_lat), 1);
    check("sim_drv",  int'(drv_en),    0);
    fault = 1'b0;
    en = 1'b0;
    ticks(2);

    // Randomized en/fault traffic
    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      fault = (r < 4);
      if (r >= 4 && r < 10) en = ~en;
      tick();
    end
    fault = 1'b0;
    en = 1'b0;
    ticks(2);

    // Default parameters: ss_done latency and single-LSB monotonic steps
    en_d = 1'b1;
    cnt  = 0;
    prev = 0;
    while (cnt < 5000) begin
      @(posedge clk);
      #1;
      if (int'(ss_code_d) != prev) begin
        check("def_step", int'(ss_code_d), prev + 1);
        prev = int'(ss_code_d);
      end
      if (ss_done_d) break;
      cnt++;
    end
    check("def_done_edge", cnt, DB + DF * DP);
    check("def_final_code", int'(ss_code_d), DF);
    check("def_drv", int'(drv_en_d), 1);
    check("def_ramp_act", int'(ramp_act_d), 0);
    en_d = 1'b0;
    @(posedge clk);
    #1;
    check("def_off_code", int'(ss_code_d), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
